cmp_match_bank: RTL

Parametrised multi-channel registered comparator bank; successor to the 6-bit active-low equality compare used in the TOM address/data match paths. Each channel holds a programmable reference value and don't-care mask. Channels compare a streamed input word and report per-channel active-low match, a priority-encoded first hit, sticky hit flags and saturating hit counters. Sits beside the object processor / blitter as a general match/trigger resource.

---
 rtl/cmp_match_pkg.sv | 27 ++
 rtl/cmp_match_chan.sv | 75 +++++++
 rtl/cmp_match_bank.sv | 96 +++++++++
 3 files changed

// File: rtl/cmp_match_pkg.sv
// rtl/cmp_match_pkg.sv - shared compare-mode encodings and sizing helpers for the comparator bank (optional magnitude modes: CMP_MAGNITUDE_EN)
package cmp_match_pkg;

  // Per-channel compare mode; the reserved code behaves as masked equality.
  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_LT  = 2'b01,
    CMP_GE  = 2'b10,
    CMP_RSV = 2'b11
  } cmp_mode_e;

  // Channel index width: a single channel still gets a 1-bit index.
  function automatic int idx_w(input int channels);
    return (channels <= 1) ? 1 : $clog2(channels);
  endfunction

  // Extract channel ch's counter from a packed hit_cnt vector (channel 0 in LSBs).
  function automatic logic [31:0] cnt_slice(input logic [511:0] cnt_vec, input int ch,
                                            input int cnt_w);
    logic [511:0] shifted;
    logic [31:0]  keep;
    shifted = cnt_vec >> (ch * cnt_w);
    keep    = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
    return shifted[31:0] & keep;
  endfunction

endpackage

// File: rtl/cmp_match_chan.sv
// rtl/cmp_match_chan.sv - one comparator channel: reference/mask/mode storage and raw match (magnitude modes under CMP_MAGNITUDE_EN)
module cmp_match_chan
  import cmp_match_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_ref,
  input  logic [WIDTH-1:0] ld_mask,
`ifdef CMP_MAGNITUDE_EN
  input  logic [1:0]       ld_mode,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             raw_match
);

  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] data_m;
  logic [WIDTH-1:0] ref_m;
  logic             cond;

`ifdef CMP_MAGNITUDE_EN
  cmp_mode_e        mode_q;

  // Reference, mask and mode storage; a load lands at the edge so a same-cycle compare sees old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q  <= '0;
      mask_q <= '0;
      mode_q <= CMP_EQ;
    end else if (ld) begin
      ref_q  <= ld_ref;
      mask_q <= ld_mask;
      mode_q <= cmp_mode_e'(ld_mode);
    end
  end

  // Masked equality or unsigned magnitude compare on the masked operands.
  always_comb begin
    data_m = in_data & mask_q;
    ref_m  = ref_q & mask_q;
    case (mode_q)
      CMP_LT:  cond = (data_m < ref_m);
      CMP_GE:  cond = (data_m >= ref_m);
      default: cond = (data_m == ref_m);
    endcase
  end
`else
  // Reference and mask storage; a load lands at the edge so a same-cycle compare sees old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q  <= '0;
      mask_q <= '0;
    end else if (ld) begin
      ref_q  <= ld_ref;
      mask_q <= ld_mask;
    end
  end

  // Masked equality only.
  always_comb begin
    data_m = in_data & mask_q;
    ref_m  = ref_q & mask_q;
    cond   = (data_m == ref_m);
  end
`endif

  // An all-zero mask disables the channel rather than acting as a wildcard.
  assign raw_match = in_valid && (mask_q != '0) && cond;

endmodule

// File: rtl/cmp_match_bank.sv
// rtl/cmp_match_bank.sv - multi-channel registered comparator bank with priority hit, sticky flags and saturating counters (optional ld_mode port: CMP_MAGNITUDE_EN)
module cmp_match_bank
  import cmp_match_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4,
  parameter int IDX_W    = idx_w(CHANNELS)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      ld,
  input  logic [IDX_W-1:0]          ld_sel,
  input  logic [WIDTH-1:0]          ld_ref,
  input  logic [WIDTH-1:0]          ld_mask,
`ifdef CMP_MAGNITUDE_EN
  input  logic [1:0]                ld_mode,
`endif
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      clr,
  output logic [CHANNELS-1:0]       match_n,
  output logic                      hit_valid,
  output logic [IDX_W-1:0]          hit_idx,
  output logic [CHANNELS-1:0]       sticky,
  output logic [CHANNELS*CNT_W-1:0] hit_cnt
);

  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] ld_en;
  logic [IDX_W-1:0]    first_idx;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             sticky_q;
    logic [CNT_W-1:0] cnt_q;

    // Out-of-range selects decode to no channel, so they change nothing.
    assign ld_en[c] = ld && (ld_sel == IDX_W'(c));

    cmp_match_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .ld       (ld_en[c]),
      .ld_ref   (ld_ref),
      .ld_mask  (ld_mask),
`ifdef CMP_MAGNITUDE_EN
      .ld_mode  (ld_mode),
`endif
      .in_valid (in_valid),
      .in_data  (in_data),
      .raw_match(raw[c])
    );

    // Sticky flag and saturating counter; clr wins over a same-cycle match.
    always_ff @(posedge sys_clk) begin
      if (sys_rst || clr) begin
        sticky_q <= 1'b0;
        cnt_q    <= '0;
      end else if (raw[c]) begin
        sticky_q <= 1'b1;
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign sticky[c]                   = sticky_q;
    assign hit_cnt[c*CNT_W +: CNT_W]   = cnt_q;
  end

  // Priority encoder: lowest-numbered matching channel, 0 when nothing matches.
  always_comb begin
    first_idx = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (raw[c]) begin
        first_idx = IDX_W'(c);
      end
    end
  end

  // Registered compare results; raw already folds in in_valid.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      match_n   <= '1;
      hit_valid <= 1'b0;
      hit_idx   <= '0;
    end else begin
      match_n   <= ~raw;
      hit_valid <= |raw;
      hit_idx   <= first_idx;
    end
  end

endmodule
